// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Declarations shared by the UART transmitter and receiver: the fixed line
// rate, the 2-bit frame state encoding, and the helper that turns a system
// clock frequency into clocks per bit.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int BAUD_HZ = 100000;

    // Encoding is shared with uart_tx, so the values are pinned explicitly.
    typedef enum logic [1:0] {
        s_idle  = 2'd0,
        s_start = 2'd1,
        s_bit   = 2'd2,
        s_stop  = 2'd3
    } uart_state_e;

    function automatic int cycles_per_bit(input int clk_hz);
        return clk_hz / BAUD_HZ;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous serial line into the clk domain and derives the
// signals the receiver FSM needs.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset (all flops reset to 1)
//   rx_async   in   raw serial line, idle high
//   rx_s       out  line after a 2-flop synchroniser
//   rx_fall    out  high for one cycle when rx_s has just gone 1 -> 0
//   rx_sample  out  value to use at a bit sample point
//
// Build option UART_RX_MAJORITY_EN: when defined, rx_sample is the majority
// of rx_s over the current and two preceding cycles; otherwise rx_sample is
// rx_s itself.
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_async,
    output logic rx_s,
    output logic rx_fall,
    output logic rx_sample
);

    logic sync1_q;
    logic rx_s_q;
    logic rx_d_q;

    // Flops reset to 1 so that leaving reset never looks like a start edge.
    // NOTE: non-blocking assignments make every flop take its pre-edge input;
    // blocking ones would collapse this chain into a single flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= rx_async;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    assign rx_s    = rx_s_q;
    assign rx_fall = rx_d_q & ~rx_s_q;

`ifdef UART_RX_MAJORITY_EN
    logic rx_d2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_d2_q <= 1'b1;
        end else begin
            rx_d2_q <= rx_d_q;
        end
    end

    // A single-cycle disturbance cannot outvote the two neighbouring samples.
    assign rx_sample = (rx_s_q & rx_d_q) | (rx_s_q & rx_d2_q) | (rx_d_q & rx_d2_q);
`else
    assign rx_sample = rx_s_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver at the fixed package baud rate. Validates the start bit
// at mid-bit, samples eight data bits LSB-first at bit centres, checks the
// stop bit and presents each good byte with a one-cycle strobe.
//
// Parameters:
//   CLK_HZ         system clock frequency in Hz (clocks per bit must be >= 4)
//   COUNTER_WIDTH  bit-timer width
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   UART_RX        in   serial line, idle high, asynchronous to clk
//   data           out  last correctly framed byte, held until the next one
//   valid          out  one-cycle strobe, data is new this cycle
//   framing_error  out  one-cycle strobe, stop bit was sampled low
//   busy           out  high while a frame is in progress
//
// Build option UART_RX_MAJORITY_EN: majority-of-three sampling (see
// uart_rx_sync). Sample points and latency are the same either way.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ        = 1000000,
    parameter int COUNTER_WIDTH = $clog2(cycles_per_bit(CLK_HZ))
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int N = cycles_per_bit(CLK_HZ);
    localparam int H = N / 2;
    localparam logic [COUNTER_WIDTH-1:0] BIT_LAST  = COUNTER_WIDTH'(N - 1);
    localparam logic [COUNTER_WIDTH-1:0] HALF_LAST = COUNTER_WIDTH'(H - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE   = COUNTER_WIDTH'(1);

    // The plain synchronised level is not needed here: edge detection and
    // sampling both come from dedicated outputs of the synchroniser.
    logic rx_s_unused;
    logic rx_fall;
    logic rx_sample;

    uart_rx_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .rx_async  (UART_RX),
        .rx_s      (rx_s_unused),
        .rx_fall   (rx_fall),
        .rx_sample (rx_sample)
    );

    uart_state_e              state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]               bit_q, bit_d;
    logic [7:0]               shift_q, shift_d;
    logic [7:0]               data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     ferr_q, ferr_d;
    logic                     busy_q, busy_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            s_idle: begin
                // Edge-triggered so a line stuck low cannot restart frames.
                if (rx_fall) begin
                    state_d = s_start;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end

            s_start: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    // High at mid start bit means a glitch, not a frame.
                    state_d = rx_sample ? s_idle : s_bit;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            s_bit: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_sample;
                    if (bit_q == 3'd7) begin
                        state_d = s_stop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            s_stop: begin
                if (cnt_q == BIT_LAST) begin
                    // Leave at the stop-bit centre: half a bit of slack
                    // before a back-to-back start edge can arrive.
                    cnt_d   = '0;
                    state_d = s_idle;
                    if (rx_sample) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: state_d = s_idle;
        endcase

        // Registered from the next state so busy drops with the strobe edge.
        busy_d = (state_d != s_idle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= s_idle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign data          = data_q;
    assign valid         = valid_q;
    assign framing_error = ferr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at CLK_HZ = 1 MHz (10 clocks per bit).
// Frames are driven on the falling clock edge; expected strobes are queued
// before each frame and consumed by a monitor that samples on the falling
// edge. Honours UART_RX_MAJORITY_EN for the mid-bit glitch scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int N = 10;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       rx_pin = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       busy;

    uart_rx #(.CLK_HZ(1000000)) dut (
        .clk           (clk),
        .reset         (reset),
        .UART_RX       (rx_pin),
        .data          (data),
        .valid         (valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       is_ferr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] tx_byte;
        logic       stop_level;
        int         stop_cycles;
        int         gap;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    exp_t sb_q[$];
    exp_t sb_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   busy_rise_cyc = 0;
    int   busy_fall_cyc = 0;
    int   strobe_cyc    = 0;
    int   strobe_count  = 0;
    logic prev_busy     = 1'b0;
    logic prev_strobe   = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (busy && !prev_busy) busy_rise_cyc = cyc;
            if (!busy && prev_busy) busy_fall_cyc = cyc;
            if (valid || framing_error) begin
                strobe_count++;
                strobe_cyc = cyc;
                check("strobe_exclusive", {31'b0, valid & framing_error}, 32'd0);
                check("strobe_width", {31'b0, prev_strobe}, 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: valid=%0b framing_error=%0b data=0x%02h, none expected",
                             valid, framing_error, data);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("strobe_kind", {31'b0, framing_error}, {31'b0, sb_e.is_ferr});
                    check("rx_data", {24'b0, data}, {24'b0, sb_e.data});
                end
            end
        end
        prev_busy   = busy;
        prev_strobe = valid | framing_error;
    end

    // ---------------- stimulus helpers ----------------
    // Drives start + 8 data bits (N cycles each) then the stop level for
    // stop_cycles. glitch_at inverts the line for the one cycle at that
    // offset from the start of the frame (-1: no glitch).
    task automatic send_frame(input logic [7:0] b, input logic stop_level,
                              input int stop_cycles, input int glitch_at,
                              output int start_cyc);
        logic [8:0] bits;
        bits = {b, 1'b0};
        start_cyc = 0;
        for (int i = 0; i < 9 * N + stop_cycles; i++) begin
            logic lvl;
            @(negedge clk);
            if (i == 0) start_cyc = cyc;
            lvl = (i < 9 * N) ? bits[i / N] : stop_level;
            if (i == glitch_at) lvl = ~lvl;
            rx_pin = lvl;
        end
    endtask

    task automatic idle_line(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_pin = 1'b1;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t       vecs [6];
        int         sc;
        logic [8:0] rbits;
        logic [7:0] glitch_exp;

        vecs[0] = '{8'hA5, 1'b1, 10, 10, 1'b0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 10,  0, 1'b0, 8'h00};  // back-to-back with next
        vecs[2] = '{8'hFF, 1'b1, 10, 10, 1'b0, 8'hFF};
        vecs[3] = '{8'h11, 1'b1, 10, 10, 1'b0, 8'h11};
        vecs[4] = '{8'h3C, 1'b0, 20, 10, 1'b1, 8'h11};  // stop low: data holds
        vecs[5] = '{8'h7E, 1'b1, 10, 10, 1'b0, 8'h7E};

        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data",  {24'b0, data}, 32'd0);
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_ferr",  {31'b0, framing_error}, 32'd0);
        check("reset_busy",  {31'b0, busy}, 32'd0);
        reset = 1'b0;
        idle_line(5);
        check("idle_busy", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{vecs[i].exp_ferr, vecs[i].exp_data});
            send_frame(vecs[i].tx_byte, vecs[i].stop_level, vecs[i].stop_cycles, -1, sc);
            if (i == 0) begin
                // E = busy rise; start sample at E+5, strobe after E+95.
                check("a5_start_latency", busy_rise_cyc - sc, 32'd3);
                check("a5_strobe_latency", strobe_cyc - busy_rise_cyc, 32'd95);
                check("a5_busy_fall", busy_fall_cyc, strobe_cyc);
            end
            check("sb_drained", sb_q.size(), 32'd0);
            idle_line(vecs[i].gap);
        end
        check("data_hold_7e", {24'b0, data}, 32'h7E);

        // 3-cycle low glitch on an idle line: false start, no strobe.
        idle_line(10);
        @(negedge clk);
        sc = cyc;
        rx_pin = 1'b0;
        repeat (3) @(negedge clk);
        rx_pin = 1'b1;
        idle_line(20);
        check("glitch_busy_rise", busy_rise_cyc - sc, 32'd3);
        check("glitch_busy_len", busy_fall_cyc - busy_rise_cyc, 32'd5);
        check("glitch_busy_low", {31'b0, busy}, 32'd0);
        check("glitch_no_strobe", strobe_count, 32'd6);

        // Reset in the middle of bit 4 of 0x5A.
        rbits = {8'h5A, 1'b0};
        for (int i = 0; i < 5 * N + 5; i++) begin
            @(negedge clk);
            rx_pin = rbits[i / N];
        end
        @(negedge clk);
        check("midframe_busy", {31'b0, busy}, 32'd1);
        reset  = 1'b1;
        rx_pin = 1'b1;
        @(negedge clk);
        check("abort_data",  {24'b0, data}, 32'd0);
        check("abort_valid", {31'b0, valid}, 32'd0);
        check("abort_ferr",  {31'b0, framing_error}, 32'd0);
        check("abort_busy",  {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_line(20);
        check("abort_no_strobe", strobe_count, 32'd6);
        sb_q.push_back('{1'b0, 8'h5A});
        send_frame(8'h5A, 1'b1, 10, -1, sc);
        idle_line(5);
        check("after_abort_drained", sb_q.size(), 32'd0);
        check("after_abort_data", {24'b0, data}, 32'h5A);

        // One-cycle inverted glitch at the bit-3 sample point of 0x0F.
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h0F;
`else
        glitch_exp = 8'h07;
`endif
        sb_q.push_back('{1'b0, glitch_exp});
        send_frame(8'h0F, 1'b1, 10, 45, sc);
        idle_line(5);
        check("bit3_glitch_drained", sb_q.size(), 32'd0);
        check("bit3_glitch_data", {24'b0, data}, {24'b0, glitch_exp});

        idle_line(20);
        check("total_strobes", strobe_count, 32'd8);
        check("final_sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver, the receive-side counterpart of `uart_tx`, at the same fixed 100 kbaud (`CLK_HZ/100000` clocks per bit). It synchronises the asynchronous serial line and validates the start bit at mid-bit. It samples eight data bits LSB-first at bit centres, checks the stop bit, then presents each byte with a one-cycle strobe. It sits between the board-level UART input pin and any command/byte consumer in the fabric.

## Interface
- `CLK_HZ`, default 1000000: system clock frequency in Hz. `CYCLES_PER_BIT` (N) = `CLK_HZ/100000`; must be ≥ 4.
- `COUNTER_WIDTH`, default `$clog2(CYCLES_PER_BIT)`: bit-timer width.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `UART_RX` input 1: serial line, idle high, asynchronous to `clk`.
- `data` output 8: last correctly framed byte; holds until the next good frame.
- `valid` output 1: one-cycle strobe; `data` is new in this cycle.
- `framing_error` output 1: one-cycle strobe when the stop bit is sampled low.
- `busy` output 1: high whenever state ≠ `s_idle`.

## Operation
- `UART_RX` passes through a 2-flop synchroniser (flops reset to 1) to give `rx_s`. A further flop `rx_d` holds the previous `rx_s`.
- States:
  - `s_idle`: on a falling edge (`rx_d`=1, `rx_s`=0) go to `s_start` with counter 0 and bit index 0. A line that is held low does not start a frame.
  - `s_start`: count to H−1, where H = N/2 (integer). At H−1, sample the line. If 0, go to `s_bit` with counter 0. If 1, it is a false start: go to `s_idle` with no strobe.
  - `s_bit`: count to N−1. At N−1, sample into `shift[bit]` and reset the counter. Increment `bit` while `bit` < 7; after bit 7, go to `s_stop`.
  - `s_stop`: count to N−1, then sample the line.
    - Sample 1: `data` ← `shift`, `valid` ← 1.
    - Sample 0: `framing_error` ← 1 and `data` is unchanged.
    - Either way, go to `s_idle`.
- Returning to `s_idle` at the stop-bit centre leaves half a bit of margin for back-to-back frames.
- After a framing error, the falling-edge rule blocks re-triggering until the line has returned high.
- The counter is `COUNTER_WIDTH` bits, compares against N−1 and H−1, and never wraps.

## Timing
- Reset values:
  - `data`=0, `valid`=0, `framing_error`=0, `busy`=0.
  - State `s_idle`, counter 0, bit index 0, shift register 0.
  - Synchroniser flops and `rx_d` = 1.
- Let E be the clock edge at which `s_idle` registers the falling edge of `rx_s`. This is 2–3 cycles after the pin edge.
  - Start sample at E+H.
  - Data bit k (k=0..7) sampled at E+H+(k+1)·N.
  - Stop bit sampled at E+H+9N.
  - `valid` or `framing_error` is high for exactly the cycle after E+H+9N; `busy` falls on that same edge.
- `valid` and `framing_error` are never high together.
- No backpressure: the consumer must take `data` on `valid`. `data` remains stable at least until the next `valid`.
- Reset asserted mid-frame aborts immediately to the reset values. No strobe is emitted for the partial frame.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - Defined: a 3-deep history of `rx_s` is kept. Every sample point (start, data, stop) uses the majority of `rx_s` at the sample cycle and the two preceding cycles. Sample cycles and latency are unchanged.
  - Undefined: every sample point uses the single `rx_s` value in the sample cycle.

## Structure
- Shared package `uart_pkg` holds:
  - `BAUD_HZ` = 100000.
  - The 2-bit state encoding `s_idle`=0, `s_start`=1, `s_bit`=2, `s_stop`=3, shared with `uart_tx`.
  - A function computing `CYCLES_PER_BIT` from `CLK_HZ`.
- One sub-module: `uart_rx_sync`, the 2-flop synchroniser plus `rx_d` and the optional 3-sample majority history. It outputs `rx_s`, `rx_fall` and `rx_sample`.

## Test plan
All scenarios use CLK_HZ=1000000 (N=10, H=5) and ideal 10-cycle bits unless stated otherwise.
- Send 0xA5 → `data`=0xA5, `valid` high for exactly one cycle at E+95, `framing_error` stays 0, `busy` high for E+1..E+95.
- Send 0x00 then 0xFF back-to-back with no idle gap → two `valid` pulses, `data`=0x00 then 0xFF.
- 3-cycle low glitch on an idle line → no `valid`, no `framing_error`; `busy` drops after the start-bit check.
- Send 0x3C after a good 0x11, with the stop bit driven low for 20 cycles → one `framing_error` pulse and `data` stays 0x11. A following 0x7E is received correctly once the line returns high.
- Assert `reset` during bit 4 of 0x5A → all outputs 0 next cycle and no strobe. A subsequent 0x5A gives `valid` with `data`=0x5A.
- 1-cycle inverted glitch exactly at the bit-3 sample point of 0x0F:
  - With `UART_RX_MAJORITY_EN` → `data`=0x0F.
  - Without it → `data`=0x07.
